// File: rtl/top_level_pattern.sv
// Pattern-count engine: scans a 32-byte string in data memory for a 5-bit pattern
// and writes the within-byte, byte and full-string match counts back to memory.

module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] raddr,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] core [256];

   assign rdata = core[raddr];

   always_ff @(posedge clk) begin
      if (we)
         core[waddr] <= wdata;
   end

endmodule

module top_level_pattern #(
   parameter int STR_BASE  = 0,
   parameter int STR_BYTES = 32,
   parameter int PAT_ADDR  = 32,
   parameter int RES_ADDR  = 33
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic done
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      WR0,
      WR1,
      WR2,
      DONE
   } state_t;

   state_t     state;
   state_t     state_next;
   logic       done_next;

   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       mem_we;
   logic [7:0] mem_waddr;
   logic [7:0] mem_wdata;

   logic [4:0] pat;
   logic [3:0] prev;
   logic [7:0] idx;
   logic [7:0] ctb;
   logic [7:0] cto;
   logic [7:0] cts;

   logic [2:0] byte_hits;
   logic [2:0] cross_hits;
   logic [7:0] cross_win;

   data_mem dm1 (
      .clk   (clk),
      .we    (mem_we),
      .raddr (rd_addr),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .rdata (rd_data)
   );

   // Only the low nibble of the previous byte can take part in a window that
   // straddles the byte boundary, so that is all we keep of it.
   assign cross_win = {prev, rd_data[7:4]};

   always_comb begin
      byte_hits  = 3'd0;
      cross_hits = 3'd0;
      for (int k = 0; k < 4; k++) begin
         byte_hits  = byte_hits  + {2'b00, (rd_data[k +: 5] == pat)};
         cross_hits = cross_hits + {2'b00, (cross_win[k +: 5] == pat)};
      end
      if (idx == 8'd0)
         cross_hits = 3'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      rd_addr    = 8'(PAT_ADDR);
      mem_we     = 1'b0;
      mem_waddr  = 8'(RES_ADDR);
      mem_wdata  = ctb;
      case (state)
         IDLE: begin
            if (req)
               state_next = LOAD;
         end
         LOAD: begin
            state_next = SCAN;
         end
         SCAN: begin
            rd_addr = 8'(STR_BASE) + idx;
            if (idx == 8'(STR_BYTES - 1))
               state_next = WR0;
         end
         WR0: begin
            mem_we     = 1'b1;
            state_next = WR1;
         end
         WR1: begin
            mem_we     = 1'b1;
            mem_waddr  = 8'(RES_ADDR + 1);
            mem_wdata  = cto;
            state_next = WR2;
         end
         WR2: begin
            mem_we     = 1'b1;
            mem_waddr  = 8'(RES_ADDR + 2);
            mem_wdata  = cts;
            state_next = DONE;
         end
         DONE: begin
            if (req)
               state_next = LOAD;
            else
               done_next = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat  <= 5'd0;
         prev <= 4'd0;
         idx  <= 8'd0;
         ctb  <= 8'd0;
         cto  <= 8'd0;
         cts  <= 8'd0;
      end else begin
         case (state)
            LOAD: begin
               pat  <= rd_data[7:3];
               prev <= 4'd0;
               idx  <= 8'd0;
               ctb  <= 8'd0;
               cto  <= 8'd0;
               cts  <= 8'd0;
            end
            SCAN: begin
               ctb  <= ctb + 8'(byte_hits);
               if (byte_hits != 3'd0)
                  cto <= cto + 8'd1;
               cts  <= cts + 8'(byte_hits) + 8'(cross_hits);
               prev <= rd_data[3:0];
               idx  <= idx + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top_level_pattern.sv
// Bench for top_level_pattern: directed and random strings, results checked
// against a bit-string model of the three counts.

module tb_top_level_pattern;

   logic clk;
   logic rst_n;
   logic req;
   logic done;

   logic [7:0] str_mem [32];
   logic [7:0] pat_byte;

   int checks;
   int passes;

   top_level_pattern dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
   endtask

   // Treats the string as one 256-bit vector, core[0] first, and counts windows
   // by their starting bit position.
   function automatic void model(output int ctb, output int cto, output int cts);
      logic [255:0] s;
      logic [4:0]   p;
      int           n;
      p = pat_byte[7:3];
      for (int j = 0; j < 32; j++)
         s[255 - 8*j -: 8] = str_mem[j];
      ctb = 0;
      cto = 0;
      cts = 0;
      for (int i = 0; i < 252; i++)
         if (s[255 - i -: 5] == p) cts++;
      for (int j = 0; j < 32; j++) begin
         n = 0;
         for (int k = 0; k < 4; k++)
            if (s[255 - (8*j + k) -: 5] == p) n++;
         ctb += n;
         if (n > 0) cto++;
      end
   endfunction

   task automatic loadMemory();
      for (int i = 0; i < 32; i++)
         dut.dm1.core[i] = str_mem[i];
      dut.dm1.core[32] = pat_byte;
   endtask

   task automatic runEngine(output int lat, output int first_done);
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      lat = 99;
      first_done = 99;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) first_done = int'(done);
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic applyStimulus(output int lat);
      int fd;
      loadMemory();
      runEngine(lat, fd);
   endtask

   task automatic checkDirected(input string tag, input int e_ctb, input int e_cto, input int e_cts);
      checkOutput({tag, "_ctb"}, int'(dut.dm1.core[33]), e_ctb);
      checkOutput({tag, "_cto"}, int'(dut.dm1.core[34]), e_cto);
      checkOutput({tag, "_cts"}, int'(dut.dm1.core[35]), e_cts);
   endtask

   task automatic checkModel(input string tag);
      int m_ctb, m_cto, m_cts, diffs;
      model(m_ctb, m_cto, m_cts);
      checkDirected(tag, m_ctb, m_cto, m_cts);
      diffs = 0;
      for (int i = 0; i < 32; i++)
         if (dut.dm1.core[i] !== str_mem[i]) diffs++;
      if (dut.dm1.core[32] !== pat_byte) diffs++;
      checkOutput({tag, "_unchanged"}, diffs, 0);
   endtask

   task automatic watchNoDone(input string tag, input int cycles);
      int rises;
      rises = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (done !== 1'b0) rises++;
      end
      checkOutput(tag, rises, 0);
   endtask

   initial begin
      int lat;
      int fd;
      int r_ctb, r_cto, r_cts;

      checks = 0;
      passes = 0;
      req    = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_done", int'(done), 0);
      rst_n = 1'b1;
      watchNoDone("idle_no_done", 5);

      for (int i = 0; i < 32; i++) str_mem[i] = 8'h00;
      pat_byte = 8'h00;
      applyStimulus(lat);
      checkOutput("t1_latency", lat, 37);
      checkDirected("t1", 128, 32, 252);

      pat_byte = 8'hF8;
      applyStimulus(lat);
      checkOutput("t2_latency", lat, 37);
      checkDirected("t2", 0, 0, 0);
      repeat (5) @(negedge clk);
      checkOutput("t2_done_held", int'(done), 1);

      for (int i = 0; i < 32; i++) str_mem[i] = 8'h55;
      pat_byte = 8'hA8;
      applyStimulus(lat);
      checkOutput("t3_latency", lat, 37);
      checkDirected("t3", 64, 32, 126);

      for (int i = 0; i < 32; i++) str_mem[i] = 8'h00;
      str_mem[0] = 8'h07;
      str_mem[1] = 8'hC0;
      pat_byte = 8'hF8;
      applyStimulus(lat);
      checkOutput("t4_latency", lat, 37);
      checkDirected("t4", 0, 0, 1);

      for (int s = 0; s < 10; s++) begin
         pat_byte = 8'($urandom);
         for (int i = 0; i < 32; i++) begin
            if (s % 2 == 0)
               str_mem[i] = 8'($urandom);
            else
               str_mem[i] = {pat_byte[7:3], 3'($urandom)} ^ 8'($urandom_range(0, 1) << $urandom_range(0, 7));
         end
         applyStimulus(lat);
         checkOutput($sformatf("rand%0d_latency", s), lat, 37);
         checkModel($sformatf("rand%0d", s));
      end

      for (int i = 0; i < 32; i++) str_mem[i] = 8'($urandom);
      pat_byte = 8'($urandom);
      loadMemory();
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_done", int'(done), 0);
      rst_n = 1'b1;
      watchNoDone("abort_idle", 45);

      applyStimulus(lat);
      checkOutput("after_abort_latency", lat, 37);
      checkModel("after_abort");
      r_ctb = int'(dut.dm1.core[33]);
      r_cto = int'(dut.dm1.core[34]);
      r_cts = int'(dut.dm1.core[35]);

      runEngine(lat, fd);
      checkOutput("rerun_drop", fd, 0);
      checkOutput("rerun_latency", lat, 37);
      checkDirected("rerun", r_ctb, r_cto, r_cts);

      @(negedge clk);
      rst_n = 1'b0;
      req   = 1'b1;
      @(negedge clk);
      checkOutput("rst_beats_req", int'(done), 0);
      rst_n = 1'b1;
      req   = 1'b0;
      watchNoDone("rst_req_idle", 45);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
